pico_arb_2_1: RTL

- Two-master, one-slave arbiter on the PicoRV32 native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Lets a second bus master (DMA or video fetch engine) share one slave with the CPU. Typical slaves are the 8 KB SRAM or an output port of a 1-to-4 bus mux.
- Round-robin arbitration. The grant is locked for the whole transaction.
- A bus-timeout watchdog completes a hung transaction with an error word, so a dead slave cannot stall either master.

---
 rtl/pico_bus_pkg.sv | 15 +
 rtl/pico_bus_timeout.sv | 37 +++
 rtl/pico_arb_2_1.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pico_bus_pkg.sv
// Shared definitions for the PicoRV32 native-bus fabric: field widths, error word, arbiter states.
package pico_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic {
        StIdle,
        StBusy
    } arb_state_e;

endpackage

// File: rtl/pico_bus_timeout.sv
// Bus watchdog counter: counts enabled cycles since the last clear and flags the final allowed cycle.
module pico_bus_timeout #(
    parameter int unsigned Limit = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;
    // Limit == 0 disables the watchdog, so this value is never used in that case.
    localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire_o = (Limit != 0) && (cnt_q == LastCnt);

endmodule

// File: rtl/pico_arb_2_1.sv
// Two-master round-robin arbiter for one PicoRV32 native-bus slave, with a timeout watchdog.
module pico_arb_2_1
    import pico_bus_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              picom0_valid,
    output logic              picom0_ready,
    input  logic [ADDR_W-1:0] picom0_addr,
    input  logic [DATA_W-1:0] picom0_wdata,
    input  logic [STRB_W-1:0] picom0_wstrb,
    output logic [DATA_W-1:0] picom0_rdata,

    input  logic              picom1_valid,
    output logic              picom1_ready,
    input  logic [ADDR_W-1:0] picom1_addr,
    input  logic [DATA_W-1:0] picom1_wdata,
    input  logic [STRB_W-1:0] picom1_wstrb,
    output logic [DATA_W-1:0] picom1_rdata,

    output logic              picos_valid,
    input  logic              picos_ready,
    output logic [ADDR_W-1:0] picos_addr,
    output logic [DATA_W-1:0] picos_wdata,
    output logic [STRB_W-1:0] picos_wstrb,
    input  logic [DATA_W-1:0] picos_rdata,

    output logic              err_flag,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              err_clr
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              err_flag_q, err_flag_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic              busy;
    logic              expire;
    logic              timeout_hit;
    logic              own_valid;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic [STRB_W-1:0] own_wstrb;
    logic              own_ready;
    logic [DATA_W-1:0] own_rdata;

    assign busy      = (state_q == StBusy);
    assign own_valid = owner_q ? picom1_valid : picom0_valid;
    assign own_addr  = owner_q ? picom1_addr  : picom0_addr;
    assign own_wdata = owner_q ? picom1_wdata : picom0_wdata;
    assign own_wstrb = owner_q ? picom1_wstrb : picom0_wstrb;

    pico_bus_timeout #(
        .Limit (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk),
        .reset_i  (reset),
        .clr_i    (~busy),
        .en_i     (busy & ~picos_ready),
        .expire_o (expire)
    );

    // A slave ready on the expiry cycle is a normal completion, not a timeout.
    assign timeout_hit = busy & own_valid & ~picos_ready & expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        unique case (state_q)
            StIdle: begin
                if (picom0_valid || picom1_valid) begin
                    state_d = StBusy;
                    owner_d = (picom0_valid && picom1_valid) ? ~last_q : picom1_valid;
                end
            end
            StBusy: begin
                if (!own_valid) begin
                    state_d = StIdle;
                end else if (picos_ready || timeout_hit) begin
                    state_d = StIdle;
                    last_d  = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new timeout wins over a coincident clear and records the fresh address.
        if (timeout_hit) begin
            err_flag_d = 1'b1;
            if (!err_flag_q || err_clr) begin
                err_addr_d = own_addr;
            end
        end else if (err_clr) begin
            err_flag_d = 1'b0;
        end
    end

    always_comb begin
        picos_valid  = 1'b0;
        picos_addr   = '0;
        picos_wdata  = '0;
        picos_wstrb  = '0;
        own_ready    = 1'b0;
        own_rdata    = '0;
        picom0_ready = 1'b0;
        picom0_rdata = '0;
        picom1_ready = 1'b0;
        picom1_rdata = '0;
        if (busy && !reset) begin
            picos_valid = own_valid & ~timeout_hit;
            picos_addr  = own_addr;
            picos_wdata = own_wdata;
            picos_wstrb = own_wstrb;
            own_ready   = picos_ready | timeout_hit;
            own_rdata   = timeout_hit ? ERR_RDATA : picos_rdata;
            if (owner_q) begin
                picom1_ready = own_ready;
                picom1_rdata = own_rdata;
            end else begin
                picom0_ready = own_ready;
                picom0_rdata = own_rdata;
            end
        end
    end

    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;

endmodule
